// File: rtl/maze_pkg.sv
// Shared constants, direction encoding and FSM states for the maze wall query.
package maze_pkg;

    localparam int MAZE_W = 28;
    localparam int MAZE_H = 36;
    localparam int ADDR_W = 10;

    localparam logic [5:0] X_MAX = 6'(MAZE_W - 1);
    localparam logic [5:0] Y_MAX = 6'(MAZE_H - 1);

    // Same encoding as the ghost direction registers.
    typedef enum logic [1:0] {
        DIR_UP = 2'd0,
        DIR_DN = 2'd1,
        DIR_LF = 2'd2,
        DIR_RT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_UP = 3'd1,
        S_RD_DN = 3'd2,
        S_RD_LF = 3'd3,
        S_RD_RT = 3'd4,
        S_FLUSH = 3'd5
    } state_e;

endpackage

// File: rtl/maze_tile_addr.sv
// Combinational tile -> ROM address: addr = y*28 + x, built from shifts.
module maze_tile_addr
    import maze_pkg::*;
(
    input  logic [5:0]        x,
    input  logic [5:0]        y,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] xe;
    logic [ADDR_W-1:0] ye;

    assign xe   = ADDR_W'(x);
    assign ye   = ADDR_W'(y);
    assign addr = (ye << 4) + (ye << 3) + (ye << 2) + xe;

endmodule

// File: rtl/maze_wall_query.sv
// Per-ghost wall query responder: reads four neighbour tiles, returns walls + ack.
// Define TUNNEL_WRAP_EN to read wrapped left/right neighbours at the maze edges.
module maze_wall_query
    import maze_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [5:0]        tileX,
    input  logic [5:0]        tileY,
    output logic              busy,
    output logic              ack,
    output logic              wallUp,
    output logic              wallDown,
    output logic              wallLeft,
    output logic              wallRight,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data
);

    state_e            state_q, state_d;
    logic [5:0]        x_q, x_d;
    logic [5:0]        y_q, y_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic [3:0]        wall_q, wall_d;
    logic [3:0]        shadow_q, shadow_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              en_dly_q, en_dly_d;

    logic              accept;
    logic              oor;
    logic              slot_go;
    dir_e              slot_dir;
    logic [5:0]        src_x, src_y;
    logic [5:0]        nb_x, nb_y;
    logic              nb_ok;
    logic [ADDR_W-1:0] nb_addr;
    logic              cap_bit;

    assign accept  = (state_q == S_IDLE) && !busy_q && req;
    assign oor     = (tileX > X_MAX) || (tileY > Y_MAX);
    assign cap_bit = en_dly_q ? rom_data : 1'b1;

    // Read slot that the next cycle will issue.
    always_comb begin
        slot_go  = 1'b1;
        slot_dir = DIR_UP;
        unique case (state_q)
            S_IDLE:  slot_go  = accept && !oor;
            S_RD_UP: slot_dir = DIR_DN;
            S_RD_DN: slot_dir = DIR_LF;
            S_RD_LF: slot_dir = DIR_RT;
            default: slot_go  = 1'b0;
        endcase
    end

    always_comb begin
        src_x = (state_q == S_IDLE) ? tileX : x_q;
        src_y = (state_q == S_IDLE) ? tileY : y_q;
        nb_x  = src_x;
        nb_y  = src_y;
        nb_ok = 1'b0;
        unique case (slot_dir)
            DIR_UP: begin
                nb_ok = (src_y != 6'd0);
                nb_y  = src_y - 6'd1;
            end
            DIR_DN: begin
                nb_ok = (src_y != Y_MAX);
                nb_y  = src_y + 6'd1;
            end
            DIR_LF: begin
                if (src_x != 6'd0) begin
                    nb_ok = 1'b1;
                    nb_x  = src_x - 6'd1;
                end else begin
`ifdef TUNNEL_WRAP_EN
                    nb_ok = 1'b1;
                    nb_x  = X_MAX;
`else
                    nb_ok = 1'b0;
`endif
                end
            end
            DIR_RT: begin
                if (src_x != X_MAX) begin
                    nb_ok = 1'b1;
                    nb_x  = src_x + 6'd1;
                end else begin
`ifdef TUNNEL_WRAP_EN
                    nb_ok = 1'b1;
                    nb_x  = 6'd0;
`else
                    nb_ok = 1'b0;
`endif
                end
            end
        endcase
    end

    maze_tile_addr u_addr (
        .x    (nb_x),
        .y    (nb_y),
        .addr (nb_addr)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        wall_d     = wall_q;
        shadow_d   = shadow_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        en_dly_d   = rom_en_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (accept) begin
                    busy_d = 1'b1;
                    if (oor) begin
                        ack_d  = 1'b1;
                        wall_d = 4'hF;
                    end else begin
                        x_d     = tileX;
                        y_d     = tileY;
                        state_d = S_RD_UP;
                    end
                end
            end
            S_RD_UP: state_d = S_RD_DN;
            S_RD_DN: begin
                state_d     = S_RD_LF;
                shadow_d[0] = cap_bit;
            end
            S_RD_LF: begin
                state_d     = S_RD_RT;
                shadow_d[1] = cap_bit;
            end
            S_RD_RT: begin
                state_d     = S_FLUSH;
                shadow_d[2] = cap_bit;
            end
            S_FLUSH: begin
                state_d     = S_IDLE;
                shadow_d[3] = cap_bit;
                wall_d      = shadow_d;
                ack_d       = 1'b1;
                busy_d      = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Edge neighbours are never read; their result stays forced blocked.
        if (slot_go && nb_ok) begin
            rom_en_d   = 1'b1;
            rom_addr_d = nb_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            wall_q     <= 4'hF;
            shadow_q   <= 4'hF;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            en_dly_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            wall_q     <= wall_d;
            shadow_q   <= shadow_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            en_dly_q   <= en_dly_d;
        end
    end

    assign busy      = busy_q;
    assign ack       = ack_q;
    assign wallUp    = wall_q[0];
    assign wallDown  = wall_q[1];
    assign wallLeft  = wall_q[2];
    assign wallRight = wall_q[3];
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_maze_wall_query.sv
// Directed self-checking bench for maze_wall_query with a 1-cycle ROM model.
module tb_maze_wall_query;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic [5:0] tileX = '0;
    logic [5:0] tileY = '0;
    logic       busy, ack;
    logic       wallUp, wallDown, wallLeft, wallRight;
    logic       rom_en;
    logic [9:0] rom_addr;
    logic       rom_data = 1'b0;

    logic       mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    logic       en_a    [0:12];
    logic [9:0] addr_a  [0:12];
    logic       ack_a   [0:12];
    logic       busy_a  [0:12];
    logic [3:0] walls_a [0:12];

    always #5 clk = ~clk;

    maze_wall_query dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .tileX     (tileX),
        .tileY     (tileY),
        .busy      (busy),
        .ack       (ack),
        .wallUp    (wallUp),
        .wallDown  (wallDown),
        .wallLeft  (wallLeft),
        .wallRight (wallRight),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    // Unread cycles return 0 so a skipped slot must be forced blocked by the DUT.
    always @(posedge clk) begin
        rom_data <= rom_en ? mem[rom_addr] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] walls_now();
        return {wallRight, wallLeft, wallDown, wallUp};
    endfunction

    // Cycle T is the req cycle; index k of the arrays holds cycle T+k.
    task automatic run_query(input logic [5:0] x, input logic [5:0] y,
                             input int pulse_k, input int rst_k);
        @(negedge clk);
        req   = 1'b1;
        tileX = x;
        tileY = y;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == rst_k) begin
                reset_n = 1'b0;
                #1;
            end
            en_a[k]    = rom_en;
            addr_a[k]  = rom_addr;
            ack_a[k]   = ack;
            busy_a[k]  = busy;
            walls_a[k] = walls_now();
            @(negedge clk);
            req = (k == pulse_k);
            if (rst_k != 0 && k == rst_k + 1) reset_n = 1'b1;
        end
        req = 1'b0;
    endtask

    function automatic int count_ack();
        int n = 0;
        for (int k = 1; k <= 12; k++) n += int'(ack_a[k]);
        return n;
    endfunction

    function automatic int count_en();
        int n = 0;
        for (int k = 1; k <= 12; k++) n += int'(en_a[k]);
        return n;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 1'b0;

        // Reset state
        #12;
        check("rst_walls", 32'(walls_now()), 32'hF);
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rom_en", 32'(rom_en), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // All-open ROM, (13,16)
        run_query(6'd13, 6'd16, 0, 0);
        check("open_busy_t1", 32'(busy_a[1]), 1);
        check("open_en_t1", 32'(en_a[1]), 1);
        check("open_addr_up", 32'(addr_a[1]), 433);
        check("open_addr_dn", 32'(addr_a[2]), 489);
        check("open_addr_lf", 32'(addr_a[3]), 460);
        check("open_addr_rt", 32'(addr_a[4]), 462);
        check("open_en_t5", 32'(en_a[5]), 0);
        check("open_ack_t5", 32'(ack_a[5]), 0);
        check("open_walls_t5", 32'(walls_a[5]), 32'hF);
        check("open_ack_t6", 32'(ack_a[6]), 1);
        check("open_walls_t6", 32'(walls_a[6]), 0);
        check("open_busy_t6", 32'(busy_a[6]), 1);
        check("open_busy_t7", 32'(busy_a[7]), 0);
        check("open_ack_t7", 32'(ack_a[7]), 0);
        check("open_ack_count", 32'(count_ack()), 1);

        // Wall above (13,16)
        mem[433] = 1'b1;
        run_query(6'd13, 6'd16, 0, 0);
        check("up_hold_t5", 32'(walls_a[5]), 0);
        check("up_walls_t6", 32'(walls_a[6]), 32'b0001);
        check("up_ack_t6", 32'(ack_a[6]), 1);

        // Top row: up slot skipped, address held from last read
        run_query(6'd5, 6'd0, 0, 0);
        check("top_en_t1", 32'(en_a[1]), 0);
        check("top_addr_hold", 32'(addr_a[1]), 462);
        check("top_addr_dn", 32'(addr_a[2]), 33);
        check("top_ack_t6", 32'(ack_a[6]), 1);
        check("top_walls_t6", 32'(walls_a[6]), 32'b0001);

        // Left edge (0,17)
        run_query(6'd0, 6'd17, 0, 0);
        check("edge_addr_rt", 32'(addr_a[4]), 477);
        check("edge_ack_t6", 32'(ack_a[6]), 1);
`ifdef TUNNEL_WRAP_EN
        check("edge_en_t3", 32'(en_a[3]), 1);
        check("edge_addr_lf", 32'(addr_a[3]), 503);
        check("edge_walls_t6", 32'(walls_a[6]), 32'b0000);
`else
        check("edge_en_t3", 32'(en_a[3]), 0);
        check("edge_walls_t6", 32'(walls_a[6]), 32'b0100);
`endif

        // Out-of-range tile
        run_query(6'd28, 6'd5, 0, 0);
        check("oor_ack_t1", 32'(ack_a[1]), 1);
        check("oor_busy_t1", 32'(busy_a[1]), 1);
        check("oor_busy_t2", 32'(busy_a[2]), 0);
        check("oor_walls_t1", 32'(walls_a[1]), 32'hF);
        check("oor_en_count", 32'(count_en()), 0);
        check("oor_ack_count", 32'(count_ack()), 1);

        // req pulse during an active query is dropped
        run_query(6'd13, 6'd16, 2, 0);
        check("pulse_ack_t6", 32'(ack_a[6]), 1);
        check("pulse_ack_count", 32'(count_ack()), 1);
        check("pulse_en_count", 32'(count_en()), 4);
        check("pulse_walls_t6", 32'(walls_a[6]), 32'b0001);

        // Mid-query reset
        mem[433] = 1'b0;
        run_query(6'd13, 6'd16, 0, 3);
        check("mrst_busy", 32'(busy_a[3]), 0);
        check("mrst_walls", 32'(walls_a[3]), 32'hF);
        check("mrst_rom_en", 32'(en_a[3]), 0);
        check("mrst_rom_addr", 32'(addr_a[3]), 0);
        check("mrst_ack_count", 32'(count_ack()), 0);

        // FSM returned to idle and serves a fresh query
        run_query(6'd13, 6'd16, 0, 0);
        check("post_ack_t6", 32'(ack_a[6]), 1);
        check("post_walls_t6", 32'(walls_a[6]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
